// File: rtl/zeroriscy_trace_pkg.sv
// Shared types and constants for the zeroriscy retire-trace transmitter.
package zeroriscy_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] rd_wdata;
        logic        mem_en;
        logic [31:0] mem_addr;
        logic        ovf;
    } trace_rec_t;

    localparam int unsigned HDR_RD_WE_BIT  = 0;
    localparam int unsigned HDR_MEM_EN_BIT = 1;
    localparam int unsigned HDR_OVF_BIT    = 2;
    localparam int unsigned HDR_RD_LSB     = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_PC,
        TX_INSTR,
        TX_WDATA,
        TX_MADDR
    } tx_state_e;

    localparam int unsigned PKT_LEN_BASE = 9;
    localparam int unsigned PKT_LEN_ONE  = 13;
    localparam int unsigned PKT_LEN_FULL = 17;

    function automatic logic [7:0] header_byte(input trace_rec_t r);
        logic [7:0] h;
        h                 = '0;
        h[7:HDR_RD_LSB]   = r.rd_addr;
        h[HDR_OVF_BIT]    = r.ovf;
        h[HDR_MEM_EN_BIT] = r.mem_en;
        h[HDR_RD_WE_BIT]  = r.rd_we;
        return h;
    endfunction

    // Little-endian byte select within a 32-bit field.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/zeroriscy_trace_fifo.sv
// Synchronous record FIFO; full/empty derive from the registered occupancy count.
module zeroriscy_trace_fifo
    import zeroriscy_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_rec_t               push_rec,
    input  logic                     pop,
    output trace_rec_t               pop_rec,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    trace_rec_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_rec = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_rec;
    end

endmodule

// File: rtl/zeroriscy_trace_tx.sv
// Retire-trace transmitter: captures retire records into a FIFO and serializes
// each as a 9/13/17-byte little-endian packet on a valid/ready byte stream.
module zeroriscy_trace_tx
    import zeroriscy_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trace_en,
    input  logic                      retire_valid,
    input  logic [31:0]               retire_pc,
    input  logic [31:0]               retire_instr,
    input  logic                      retire_rd_we,
    input  logic [4:0]                retire_rd_addr,
    input  logic [31:0]               retire_rd_wdata,
    input  logic                      retire_mem_en,
    input  logic [31:0]               retire_mem_addr,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      tx_last,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    trace_rec_t       cap_rec;
    trace_rec_t       head_rec;
    trace_rec_t       cur;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_pop;
    logic             cap_req;
    logic             do_push;
    logic             do_drop;
    logic             ovf_pending;
    tx_state_e        state;
    tx_state_e        state_d;
    logic [1:0]       byte_idx;
    logic [1:0]       idx_d;

    assign cap_req = retire_valid && trace_en;
    assign do_push = cap_req && !fifo_full;
    assign do_drop = cap_req && fifo_full;

    always_comb begin
        cap_rec          = '0;
        cap_rec.pc       = retire_pc;
        cap_rec.instr    = retire_instr;
        cap_rec.rd_addr  = retire_rd_addr;
        cap_rec.rd_we    = retire_rd_we;
        cap_rec.rd_wdata = retire_rd_wdata;
        cap_rec.mem_en   = retire_mem_en;
        cap_rec.mem_addr = retire_mem_addr;
        cap_rec.ovf      = ovf_pending;
    end

    zeroriscy_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (do_push),
        .push_rec (cap_rec),
        .pop      (fifo_pop),
        .pop_rec  (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // A drop and a successful push are mutually exclusive in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pending <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (do_drop) begin
                ovf_pending <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end else if (do_push) begin
                ovf_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            byte_idx <= '0;
            cur      <= '0;
        end else begin
            state    <= state_d;
            byte_idx <= idx_d;
            if (fifo_pop) cur <= head_rec;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = byte_idx;
        fifo_pop = 1'b0;
        tx_valid = (state != TX_IDLE);
        tx_last  = 1'b0;
        tx_data  = '0;

        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = TX_HDR;
                    idx_d    = '0;
                end
            end
            TX_HDR: begin
                tx_data = header_byte(cur);
                if (tx_ready) state_d = TX_PC;
            end
            TX_PC: begin
                tx_data = word_byte(cur.pc, byte_idx);
                if (tx_ready) begin
                    idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state_d = TX_INSTR;
                end
            end
            TX_INSTR: begin
                tx_data = word_byte(cur.instr, byte_idx);
                tx_last = (byte_idx == 2'd3) && !cur.rd_we && !cur.mem_en;
                if (tx_ready) begin
                    idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state_d = cur.rd_we ? TX_WDATA : TX_MADDR;
                end
            end
            TX_WDATA: begin
                tx_data = word_byte(cur.rd_wdata, byte_idx);
                tx_last = (byte_idx == 2'd3) && !cur.mem_en;
                if (tx_ready) begin
                    idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state_d = TX_MADDR;
                end
            end
            TX_MADDR: begin
                tx_data = word_byte(cur.mem_addr, byte_idx);
                tx_last = (byte_idx == 2'd3);
                if (tx_ready) idx_d = byte_idx + 2'd1;
            end
            default: state_d = TX_IDLE;
        endcase

        // Final handshake chains straight into the next queued header.
        if (tx_last && tx_ready) begin
            idx_d = '0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                state_d  = TX_HDR;
            end else begin
                state_d  = TX_IDLE;
            end
        end
    end

    assign busy = (fifo_count != '0) || (state != TX_IDLE);

endmodule
